// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared
// combinational ALU. One operation is in flight at a time. Each operation
// goes through three phases: accept (IDLE), execute (EXEC) and respond (RESP).
//
// Handshake rule on both sides: a transfer happens on a rising edge where
// valid and ready are both high. The request side holds req_ready for the
// granted requester only, and only in IDLE. The response side holds
// rsp_valid[id] and rsp_data stable until rsp_ready[id] is seen.
module alu_arbiter #(
    parameter int OPW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OPW-1:0]  req0_op,
    input  logic [OPW-1:0]  req1_op,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [OPW-1:0]  alu_op,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    input  logic [31:0]     alu_result,
    output logic            busy,
    output logic [15:0]     done_cnt,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      result_q, result_d;
    logic [15:0]      done_cnt_q, done_cnt_d;

    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic             rsp_fire;

    // Pick a requester: a lone requester wins; on a tie, the one not served last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        unique case (req_valid)
            2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;          end
            2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;          end
            2'b11:   begin grant_vld = 1'b1; grant_id = ~last_grant_q; end
            default: begin grant_vld = 1'b0; grant_id = 1'b0;          end
        endcase
    end

    assign req_ready = (state_q == IDLE && grant_vld) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign rsp_fire  = (state_q == RESP) && rsp_ready[id_q];

    // Next-state and datapath-load logic; the other requester's rsp_ready is ignored.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        done_cnt_d   = done_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    op_d         = grant_id ? req1_op : req0_op;
                    a_d          = grant_id ? req1_a  : req0_a;
                    b_d          = grant_id ? req1_b  : req0_b;
                end
            end
            EXEC: begin
                result_d = alu_result;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d    = IDLE;
                    done_cnt_d = done_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign rsp_valid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = result_q;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_cnt_q;
    assign dbg_state = state_q;

endmodule
